// File: rtl/framebuffer_scanout_pkg.sv
// Shared constants and types for the 160x120 framebuffer and its 640x480@60 VGA scanout.
// Types for the optional FB_READBACK_EN pixel readback path also live here.
package framebuffer_scanout_pkg;

  localparam int COLOUR_BITS = 3;
  typedef logic [COLOUR_BITS-1:0] colour_t;
  typedef logic [14:0]            fb_addr_t;

  localparam logic [7:0] FB_W = 8'd160;
  localparam logic [6:0] FB_H = 7'd120;

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd752;
  localparam logic [9:0] H_TOTAL      = 10'd800;

  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd492;
  localparam logic [9:0] V_TOTAL      = 10'd525;

  typedef enum logic [1:0] {
    RB_IDLE,
    RB_READ,
    RB_ACK
  } rb_state_t;

  function automatic logic in_range(input logic [7:0] px, input logic [6:0] py);
    return (px < FB_W) && (py < FB_H);
  endfunction

  // Row-major with a 256-entry row pitch, so x and y map straight onto address bits.
  function automatic fb_addr_t fb_addr(input logic [7:0] px, input logic [6:0] py);
    return {py, px};
  endfunction

endpackage

// File: rtl/framebuffer_scanout_if.sv
// Pixel-plot bus between drawing logic (master) and the framebuffer (slave).
// FB_READBACK_EN adds the rd_* pixel readback handshake.
interface framebuffer_scanout_if #(
  parameter int COLOUR_W = 3
);
  logic [7:0]          x;
  logic [6:0]          y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;

`ifdef FB_READBACK_EN
  logic                rd_req;
  logic [7:0]          rd_x;
  logic [6:0]          rd_y;
  logic                rd_ack;
  logic [COLOUR_W-1:0] rd_colour;

  modport master (output x, y, colour, plot, rd_req, rd_x, rd_y,
                  input  rd_ack, rd_colour);
  modport slave  (input  x, y, colour, plot, rd_req, rd_x, rd_y,
                  output rd_ack, rd_colour);
`else
  modport master (output x, y, colour, plot);
  modport slave  (input  x, y, colour, plot);
`endif

endinterface

// File: rtl/framebuffer_scanout_fb_ram.sv
// 32K x COLOUR_W dual-port framebuffer RAM, read-before-write, cleared at power-up.
// Port A writes (and, with FB_READBACK_EN, also reads); port B is the scanout read port.
module fb_ram
  import framebuffer_scanout_pkg::*;
#(
  parameter int    COLOUR_W  = COLOUR_BITS,
  parameter string INIT_FILE = ""
) (
  input  logic                Clock,
  input  logic                we_a,
  input  fb_addr_t            addr_a,
  input  logic [COLOUR_W-1:0] wdata_a,
`ifdef FB_READBACK_EN
  output logic [COLOUR_W-1:0] rdata_a,
`endif
  input  fb_addr_t            addr_b,
  output logic [COLOUR_W-1:0] rdata_b
);

  logic [COLOUR_W-1:0] mem [0:(1 << 15) - 1];

  // Power-up image only; reset never reloads it.
  initial begin
    for (int i = 0; i < (1 << 15); i++) mem[i] = '0;
  end

  // NOTE: the array has no reset branch -- a reset loop over 32K words cannot map onto block RAM.
  always_ff @(posedge Clock) begin
    if (we_a) mem[addr_a] <= wdata_a;
`ifdef FB_READBACK_EN
    rdata_a <= mem[addr_a];
`endif
  end

  // Same-address collision with port A returns the old word.
  always_ff @(posedge Clock) begin
    rdata_b <= mem[addr_b];
  end

endmodule

// File: rtl/framebuffer_scanout.sv
// 160x120 framebuffer scanned out as 640x480@60 VGA with 4x4 pixel replication.
// Define FB_READBACK_EN to add the rd_* pixel readback port sharing RAM port A.
module framebuffer_scanout
  import framebuffer_scanout_pkg::*;
#(
  parameter int    COLOUR_W  = COLOUR_BITS,
  parameter string INIT_FILE = "background.mif"
) (
  input  logic                 Clock,
  input  logic                 Reset,
  framebuffer_scanout_if.slave plot_bus,
  output logic [7:0]           VGA_R,
  output logic [7:0]           VGA_G,
  output logic [7:0]           VGA_B,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 VGA_BLANK_N,
  output logic                 VGA_SYNC_N,
  output logic                 VGA_CLK
);

  logic                pix_en;
  logic [9:0]          hcount;
  logic [9:0]          vcount;
  logic                visible;
  logic                hs_n;
  logic                vs_n;
  logic                vis_q;
  logic                hs_q;
  logic                vs_q;
  fb_addr_t            port_b_addr;
  logic [COLOUR_W-1:0] pix_q;
  logic                port_a_we;
  fb_addr_t            port_a_addr;

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pix_en <= 1'b0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (hcount == H_TOTAL - 10'd1) begin
          hcount <= '0;
          vcount <= (vcount == V_TOTAL - 10'd1) ? '0 : vcount + 10'd1;
        end else begin
          hcount <= hcount + 10'd1;
        end
      end
    end
  end

  always_comb begin
    visible     = (hcount < H_VISIBLE) && (vcount < V_VISIBLE);
    hs_n        = !((hcount >= H_SYNC_START) && (hcount < H_SYNC_END));
    vs_n        = !((vcount >= V_SYNC_START) && (vcount < V_SYNC_END));
    port_b_addr = {vcount[8:2], hcount[9:2]};
  end

  // Stage 1: RAM read in flight; timing flags delayed alongside it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      vis_q <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      vis_q <= visible;
      hs_q  <= hs_n;
      vs_q  <= vs_n;
    end
  end

  // Stage 2: pin registers, colour blanked outside the visible window.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      VGA_R       <= 8'h00;
      VGA_G       <= 8'h00;
      VGA_B       <= 8'h00;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else begin
      VGA_R       <= {8{vis_q & pix_q[2]}};
      VGA_G       <= {8{vis_q & pix_q[1]}};
      VGA_B       <= {8{vis_q & pix_q[0]}};
      VGA_HS      <= hs_q;
      VGA_VS      <= vs_q;
      VGA_BLANK_N <= vis_q;
    end
  end

  assign VGA_CLK    = pix_en;
  assign VGA_SYNC_N = 1'b0;

  assign port_a_we = plot_bus.plot && in_range(plot_bus.x, plot_bus.y);

`ifdef FB_READBACK_EN
  rb_state_t           rb_state;
  rb_state_t           rb_next;
  logic [COLOUR_W-1:0] rd_data_a;
  logic [COLOUR_W-1:0] rd_colour_q;

  // Plot owns port A whenever it is high; readback only borrows idle cycles.
  assign port_a_addr = plot_bus.plot ? fb_addr(plot_bus.x, plot_bus.y)
                                     : fb_addr(plot_bus.rd_x, plot_bus.rd_y);

  always_ff @(posedge Clock) begin
    if (Reset) rb_state <= RB_IDLE;
    else       rb_state <= rb_next;
  end

  // NOTE: rb_next gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    rb_next = rb_state;
    case (rb_state)
      RB_IDLE: if (plot_bus.rd_req && !plot_bus.plot) rb_next = RB_READ;
      RB_READ: rb_next = RB_ACK;
      RB_ACK:  rb_next = RB_IDLE;
      default: rb_next = RB_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_colour_q <= '0;
    end else if (rb_state == RB_READ) begin
      rd_colour_q <= in_range(plot_bus.rd_x, plot_bus.rd_y) ? rd_data_a : '0;
    end
  end

  assign plot_bus.rd_ack    = (rb_state == RB_ACK);
  assign plot_bus.rd_colour = rd_colour_q;
`else
  assign port_a_addr = fb_addr(plot_bus.x, plot_bus.y);
`endif

  fb_ram #(
    .COLOUR_W  (COLOUR_W),
    .INIT_FILE (INIT_FILE)
  ) u_fb_ram (
    .Clock   (Clock),
    .we_a    (port_a_we),
    .addr_a  (port_a_addr),
    .wdata_a (plot_bus.colour),
`ifdef FB_READBACK_EN
    .rdata_a (rd_data_a),
`endif
    .addr_b  (port_b_addr),
    .rdata_b (pix_q)
  );

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Self-checking bench for framebuffer_scanout: every output pin compared each Clock against a
// pixel-time reference model; FB_READBACK_EN enables the readback section.
module tb_framebuffer_scanout;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  framebuffer_scanout_if #(.COLOUR_W(3)) bus ();

  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;

  framebuffer_scanout #(
    .COLOUR_W  (3),
    .INIT_FILE ("")
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .plot_bus    (bus),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_SYNC_N  (VGA_SYNC_N),
    .VGA_CLK     (VGA_CLK)
  );

  always #10 Clock = ~Clock;

  int         checks = 0;
  int         errors = 0;
  int         k = 0;          // Clock edges since Reset was last released
  bit         rst_s = 1'b1;   // Reset as sampled by the most recent edge
  logic [2:0] fb_m [120][160];
  int         first_fall;
  int         second_fall;
  int         blank0;
  bit         prev_hs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Each display pixel lasts two Clocks and the pins lag the pixel position by two Clocks,
  // so the pins after edge k show pixel number (k-2)/2 of the raster since release.
  function automatic logic [31:0] exp_pins();
    int         p, h, v;
    logic       vis, hs, vs;
    logic [2:0] c;
    if (rst_s || k < 2)
      return {3'b0, 24'h0, 1'b1, 1'b1, 1'b0, (!rst_s && k == 1), 1'b0};
    p   = (k - 2) / 2;
    h   = p % 800;
    v   = (p / 800) % 525;
    vis = (h < 640) && (v < 480);
    hs  = !((h >= 656) && (h < 752));
    vs  = !((v >= 490) && (v < 492));
    c   = vis ? fb_m[v / 4][h / 4] : 3'b000;
    return {3'b0, {8{c[2]}}, {8{c[1]}}, {8{c[0]}}, hs, vs, vis, (k % 2 == 1), 1'b0};
  endfunction

  task automatic tick();
    @(posedge Clock);
    rst_s = Reset;
    if (Reset) k = 0;
    else       k++;
    #1;
    check($sformatf("pins k=%0d", k),
          {3'b0, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK, VGA_SYNC_N},
          exp_pins());
    if (!rst_s) begin
      if (prev_hs && !VGA_HS) begin
        if (first_fall < 0)       first_fall = k;
        else if (second_fall < 0) second_fall = k;
      end
      if (k <= 1601 && VGA_BLANK_N) blank0++;
    end
    prev_hs = VGA_HS;
  endtask

  task automatic write_px(input int px, input int py, input logic [2:0] c);
    bus.x      = px[7:0];
    bus.y      = py[6:0];
    bus.colour = c;
    bus.plot   = 1'b1;
    tick();
    if (px < 160 && py < 120) fb_m[py][px] = c;
  endtask

  // Advance until the raster position (pixels since release) reaches pc.
  task automatic run_until(input int pc);
    while (k / 2 < pc) tick();
  endtask

  task automatic clear_tracking();
    first_fall  = -1;
    second_fall = -1;
    blank0      = 0;
    prev_hs     = 1'b1;
  endtask

  task automatic check_line_timing(input string phase);
    check({phase, " first_hs_fall"}, first_fall, 1314);
    check({phase, " hs_period"}, second_fall - first_fall, 1600);
    check({phase, " blank_n_line0"}, blank0, 1280);
  endtask

  initial begin
    int rx;
    bus.plot   = 1'b0;
    bus.x      = '0;
    bus.y      = '0;
    bus.colour = '0;
`ifdef FB_READBACK_EN
    bus.rd_req = 1'b0;
    bus.rd_x   = '0;
    bus.rd_y   = '0;
`endif
    clear_tracking();

    // Preload every framebuffer row the run will scan, with random colours, while in reset.
    for (int yy = 0; yy < 5; yy++)
      for (int xx = 0; xx < 160; xx++)
        write_px(xx, yy, 3'($urandom_range(7, 0)));
    bus.plot = 1'b0;
    repeat (3) tick();

    Reset = 1'b0;
    run_until(2 * 800 + 700);

    // Horizontal blanking of line 2: one in-range plot plus writes that must be dropped.
    write_px(5, 3, 3'b101);
    write_px(160, 3, 3'b111);
    write_px(200, 0, 3'b111);
    write_px(5, 120, 3'b111);
    write_px(255, 127, 3'b111);
    write_px(10, 0, 3'($urandom_range(7, 0)));
    rx = $urandom_range(159, 0);
    write_px(rx, 1, 3'($urandom_range(7, 0)));
    bus.plot = 1'b0;
    check("oob_plot_x160_kept", {29'b0, fb_m[3][160 - 160]}, {29'b0, fb_m[3][0]});

`ifdef FB_READBACK_EN
    run_until(6 * 800 + 660);
    bus.rd_x   = 8'd5;
    bus.rd_y   = 7'd3;
    bus.rd_req = 1'b1;
    bus.x      = 8'd200;
    bus.y      = 7'd0;
    bus.colour = 3'b111;
    bus.plot   = 1'b1;
    repeat (4) begin
      tick();
      check("rd_ack_while_plot", {31'b0, bus.rd_ack}, 32'd0);
    end
    bus.plot = 1'b0;
    tick();
    check("rd_ack_issue_cycle", {31'b0, bus.rd_ack}, 32'd0);
    tick();
    check("rd_ack_pulse", {31'b0, bus.rd_ack}, 32'd1);
    check("rd_colour", {29'b0, bus.rd_colour}, {29'b0, fb_m[3][5]});
    bus.rd_req = 1'b0;
    tick();
    check("rd_ack_drop", {31'b0, bus.rd_ack}, 32'd0);
    bus.rd_x   = 8'd160;
    bus.rd_y   = 7'd0;
    bus.rd_req = 1'b1;
    tick();
    check("rd_oob_issue", {31'b0, bus.rd_ack}, 32'd0);
    tick();
    check("rd_oob_ack", {31'b0, bus.rd_ack}, 32'd1);
    check("rd_oob_colour", {29'b0, bus.rd_colour}, 32'd0);
    bus.rd_req = 1'b0;
    tick();
    check("rd_oob_ack_drop", {31'b0, bus.rd_ack}, 32'd0);
`endif

    // Mid-frame reset at hcount 300; memory must survive and raster restart at (0,0).
    run_until(17 * 800 + 300);
    check_line_timing("run1");
    Reset = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
    clear_tracking();
    run_until(4 * 800 + 40);
    check_line_timing("run2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
